// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and helpers for the PS/2 keyboard receiver.
//   PS2_FRAME_BITS        bits per PS/2 frame (start, 8 data, parity, stop)
//   PS2_*_IDX             bit positions within a frame
//   PS2_BREAK/PS2_EXTEND  scan-code prefixes for the downstream decoder
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_START_IDX  = 0;
  localparam int unsigned PS2_PARITY_IDX = 9;
  localparam int unsigned PS2_STOP_IDX   = 10;

  localparam logic [7:0] PS2_BREAK  = 8'hF0;
  localparam logic [7:0] PS2_EXTEND = 8'hE0;

  // What the current ps2_clk falling edge (or timeout) does to the frame.
  typedef enum logic [1:0] {
    EvNone,
    EvCommit,
    EvError
  } rx_event_e;

  // Data plus parity must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] data_par);
    return ^data_par;
  endfunction

endpackage

// File: rtl/ps2_receiver_if.sv
// ps2_receiver_if: consumer-side byte interface of the PS/2 receiver.
//   data        FIFO head byte, valid while ready=1
//   ready       FIFO non-empty
//   overflow    sticky: a good byte was dropped on a full FIFO
//   frame_err   one-cycle pulse: a frame was discarded
//   nextdata_n  active-low pop request from the consumer
// master: the receiver; slave: the scan-code consumer.
interface ps2_receiver_if;

  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       frame_err;
  logic       nextdata_n;

  modport master (
    output data,
    output ready,
    output overflow,
    output frame_err,
    input  nextdata_n
  );

  modport slave (
    input  data,
    input  ready,
    input  overflow,
    input  frame_err,
    output nextdata_n
  );

endinterface

// File: rtl/ps2_fifo.sv
// ps2_fifo: small synchronous FIFO for received scan-code bytes.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/wdata_i write request and byte
//   pop_i          read request; ignored when empty
//   rdata_o        head entry (zero while empty), straight from storage
//   full_o/empty_o occupancy flags; count_o holds 0..Depth
//   dropped_o      push refused because full and no pop this cycle
// Depth must be a power of two >= 2 so the pointers wrap naturally.
module ps2_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o,
  output logic                   dropped_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty_o   = (count_q == '0);
    full_o    = (count_q == CntW'(Depth));
    pop_ok    = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok   = push_i & (~full_o | pop_ok);
    dropped_o = push_i & full_o & ~pop_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ps2_receiver.sv
// ps2_receiver: PS/2 keyboard frame receiver with a scan-code byte FIFO.
//   clk, clrn   system clock, asynchronous active-low reset
//   ps2_clk     PS/2 clock pin (asynchronous, idle high)
//   ps2_data    PS/2 data pin (asynchronous, idle high)
//   bus         consumer interface: data/ready/overflow/frame_err out, nextdata_n in
// Pins pass through 3-flop synchronisers; each ps2_clk falling edge advances a
// 0..10 bit counter. Good frames are committed to the FIFO on the stop-bit edge;
// bad start/parity/stop or a stalled partial frame pulse frame_err instead.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic           clk,
  input  logic           clrn,
  input  logic           ps2_clk,
  input  logic           ps2_data,
  ps2_receiver_if.master bus
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
  localparam int unsigned BitW = $clog2(PS2_FRAME_BITS);

  logic [2:0]      clk_sync_q, clk_sync_d;
  logic [2:0]      dat_sync_q, dat_sync_d;
  logic            fall, bit_in;
  logic [BitW-1:0] bit_cnt_q, bit_cnt_d;
  logic [8:0]      shift_q, shift_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            frame_err_q, frame_err_d;
  logic            overflow_q, overflow_d;
  rx_event_e       rx_ev;

  logic            fifo_empty, fifo_full, fifo_dropped;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic            pop_ok;
  logic            unused_dat_sync;

  // Synchronisers and edge detection.
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[1:0], ps2_data};
    fall       = clk_sync_q[2] & ~clk_sync_q[1];
    bit_in     = dat_sync_q[1];
  end

  // Only stage 1 of the data synchroniser is sampled; stage 2 keeps both
  // pins at the same depth.
  assign unused_dat_sync = dat_sync_q[2];

  // Frame sequencing: bit counter, shift register, checks and timeout.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    rx_ev     = EvNone;

    if (fall) begin
      to_cnt_d = '0;
      if (bit_cnt_q == BitW'(PS2_START_IDX)) begin
        // A high start bit is line noise or a lost frame: stay at 0 to resync.
        if (bit_in) begin
          rx_ev = EvError;
        end else begin
          bit_cnt_d = BitW'(1);
        end
      end else if (bit_cnt_q == BitW'(PS2_STOP_IDX)) begin
        bit_cnt_d = '0;
        if (odd_parity_ok(shift_q) && bit_in) begin
          rx_ev = EvCommit;
        end else begin
          rx_ev = EvError;
        end
      end else begin
        // Data bits then parity, LSB first: after nine shifts shift_q[7:0] is
        // the byte and shift_q[8] the parity bit.
        shift_d   = {bit_in, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + BitW'(1);
      end
    end else if (bit_cnt_q != '0) begin
      if (to_cnt_q == ToW'(TIMEOUT - 1)) begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        rx_ev     = EvError;
      end else begin
        to_cnt_d = to_cnt_q + ToW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  always_comb begin
    pop_ok      = ~bus.nextdata_n & ~fifo_empty;
    frame_err_d = (rx_ev == EvError);
    // A drop in the same cycle as a pop wins: the flag stays set.
    if (fifo_dropped) begin
      overflow_d = 1'b1;
    end else if (pop_ok) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q  <= '1;
      dat_sync_q  <= '1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(8)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (clrn),
    .push_i   (rx_ev == EvCommit),
    .wdata_i  (shift_q[7:0]),
    .pop_i    (~bus.nextdata_n),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count),
    .dropped_o(fifo_dropped)
  );

  assign bus.data      = fifo_rdata;
  assign bus.ready     = ~fifo_empty;
  assign bus.overflow  = overflow_q;
  assign bus.frame_err = frame_err_q;

  a_full_matches_count: assert property (@(posedge clk) disable iff (!clrn)
    fifo_full == (fifo_count == CntW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_ps2_receiver.sv
// tb_ps2_receiver: self-checking bench for ps2_receiver. A transaction-level
// model (byte queue, sticky overflow flag, per-cycle frame_err expectation) is
// scheduled from the frames the bench sends and compared every cycle.
module tb_ps2_receiver;
  import ps2_pkg::*;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned TIMEOUT    = 200;
  localparam int unsigned HALF       = 20;

  logic clk      = 1'b0;
  logic clrn     = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  ps2_receiver_if bus ();

  ps2_receiver #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk     (clk),
    .clrn    (clrn),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  bit         m_ovf = 1'b0;
  bit         m_err = 1'b0;
  longint     cyc = 0;
  logic [7:0] push_at[longint];
  bit         err_at[longint];
  bit         cmp_en = 1'b0;
  bit         pop_rand_en = 1'b0;
  int         err_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_ovf = 1'b0;
    m_err = 1'b0;
    push_at.delete();
    err_at.delete();
  endtask

  // Model advances on each rising edge: pop first, then the scheduled commit.
  always @(posedge clk) begin
    bit pop_ok, was_full, drop;
    cyc++;
    m_err = 1'b0;
    if (clrn) begin
      pop_ok   = !bus.nextdata_n && (m_q.size() != 0);
      was_full = (m_q.size() == FIFO_DEPTH);
      drop     = 1'b0;
      if (pop_ok) void'(m_q.pop_front());
      if (err_at.exists(cyc)) m_err = 1'b1;
      if (push_at.exists(cyc)) begin
        if (!was_full || pop_ok) m_q.push_back(push_at[cyc]);
        else drop = 1'b1;
      end
      if (drop) m_ovf = 1'b1;
      else if (pop_ok) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (clrn && cmp_en) begin
      check("ready", bus.ready, m_q.size() != 0);
      if (m_q.size() != 0) check("data", bus.data, m_q[0]);
      check("overflow", bus.overflow, m_ovf);
      check("frame_err", bus.frame_err, m_err);
    end
    if (bus.frame_err) err_seen++;
  end

  initial forever begin
    @(negedge clk);
    if (pop_rand_en) bus.nextdata_n = ($urandom_range(0, 5) != 0);
  end

  // One PS/2 bit: data set while ps2_clk high, then a low phase of HALF cycles.
  // A pin fall driven while cyc=N takes effect at rising edge N+3.
  // kind: 0 plain bit, 1 commit byte b, 2 frame_err expected.
  task automatic ps2_bit(input logic v, input int kind, input logic [7:0] b,
                         input bit pop_at_commit, input bit chk_lat, output longint fall_cyc);
    @(negedge clk);
    ps2_data = v;
    repeat (HALF / 2) @(negedge clk);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    if (kind == 1) push_at[cyc + 3] = b;
    if (kind == 2) err_at[cyc + 3] = 1'b1;
    for (int j = 1; j <= int'(HALF); j++) begin
      @(negedge clk);
      if (pop_at_commit && j == 2) bus.nextdata_n = 1'b0;
      if (pop_at_commit && j == 3) bus.nextdata_n = 1'b1;
      if (chk_lat && j == 2) check("lat_ready_early", bus.ready, 1'b0);
      if (chk_lat && j == 3) begin
        check("lat_ready", bus.ready, 1'b1);
        check("lat_data", bus.data, b);
      end
    end
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit pop_at_commit, input bit chk_lat);
    logic [10:0] bits;
    longint      fc;
    int          kind;
    bits = {1'b1 ^ bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < int'(PS2_FRAME_BITS); i++) begin
      kind = 0;
      if (i == 10) kind = (bad_par || bad_stop) ? 2 : 1;
      ps2_bit(bits[i], kind, b, (i == 10) && pop_at_commit, (i == 10) && chk_lat, fc);
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    bus.nextdata_n = 1'b0;
    @(negedge clk);
    bus.nextdata_n = 1'b1;
  endtask

  task automatic drain(output int n);
    n = 0;
    while (bus.ready && n < 2 * int'(FIFO_DEPTH)) begin
      pop_one();
      n++;
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     base, n;
    longint fc;
    bus.nextdata_n = 1'b1;
    model_clear();

    // Reset values.
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", bus.ready, 1'b0);
    check("rst_data", bus.data, 8'h00);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_frame_err", bus.frame_err, 1'b0);
    @(negedge clk);
    clrn   = 1'b1;
    cmp_en = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame, latency to ready, then pop.
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_one();
    check("t1_ready_after_pop", bus.ready, 1'b0);

    // Two frames, FIFO order.
    send_frame(PS2_BREAK, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t2_head0", bus.data, 8'hF0);
    pop_one();
    check("t2_head1", bus.data, 8'h1C);
    pop_one();
    check("t2_empty", bus.ready, 1'b0);

    // Bad parity, bad stop, bad start.
    base = err_seen;
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_par_pulses", err_seen - base, 1);
    check("t3_par_ready", bus.ready, 1'b0);
    base = err_seen;
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t3_stop_pulses", err_seen - base, 1);
    check("t3_stop_ready", bus.ready, 1'b0);
    base = err_seen;
    ps2_bit(1'b1, 2, 8'h00, 1'b0, 1'b0, fc);
    repeat (5) @(negedge clk);
    check("t3_start_pulses", err_seen - base, 1);

    // Overflow: nine frames with no pops.
    for (int i = 0; i < 9; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_overflow_set", bus.overflow, 1'b1);
    pop_one();
    check("t4_overflow_clr", bus.overflow, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t4_coincident_ovf", bus.overflow, 1'b0);
    drain(n);
    check("t4_entries", n, 8);

    // Timeout after five bits, then a clean frame.
    base = err_seen;
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'($urandom), 0, 8'h00, 1'b0, 1'b0, fc);
    err_at[fc + 3 + TIMEOUT] = 1'b1;
    repeat (TIMEOUT + 20) @(negedge clk);
    check("t5_timeout_pulses", err_seen - base, 1);
    send_frame(8'h32, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_one();

    // Reset mid-frame with three bytes queued.
    for (int i = 0; i < 3; i++) send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1, 0, 8'h00, 1'b0, 1'b0, fc);
    @(negedge clk);
    ps2_data = 1'b0;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (6) @(negedge clk);
    clrn = 1'b0;
    model_clear();
    #1;
    check("t6_rst_ready", bus.ready, 1'b0);
    check("t6_rst_overflow", bus.overflow, 1'b0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    clrn = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_one();

    // Randomised traffic with random pops and injected errors.
    pop_rand_en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      int         sel;
      b   = ($urandom_range(0, 7) == 0) ? PS2_EXTEND : 8'($urandom);
      sel = $urandom_range(0, 7);
      send_frame(b, sel == 0, sel == 1, 1'b0, 1'b0);
    end
    pop_rand_en = 1'b0;
    @(negedge clk);
    bus.nextdata_n = 1'b1;
    drain(n);
    check("t7_drained", bus.ready, 1'b0);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
